// File: rtl/matmul_pkg.sv
// matmul_pkg: state encoding and sizing/index helpers shared by the
// matrix-multiply sequencer and its MAC unit.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MAC,
        WRITE,
        DONE
    } mm_state_e;

    function automatic int aw_f(input int dim);
        return (dim * dim > 2) ? $clog2(dim * dim) : 1;
    endfunction

    function automatic int acc_w_f(input int dw, input int dim);
        return 2 * dw + $clog2(dim);
    endfunction

    // Loop-counter width; one bit minimum so DIM=2 still has a counter.
    function automatic int cw_f(input int dim);
        return (dim > 2) ? $clog2(dim) : 1;
    endfunction

    function automatic int idx(input int row, input int col, input int dim);
        return row * dim + col;
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// matmul_mac: single unsigned multiply-accumulate lane with clear/enable.
// Clear takes priority over enable.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = acc_w_f(DW, 2)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clr,
    input  logic             en,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    output logic [ACC_W-1:0] acc
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(a) * ACC_W'(b);
        end
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: i/j/k loop sequencer for a square matrix multiply.
// Optional MATMUL_SEQ_SAT_EN: saturate res_data and add the sat output.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int DIM   = 2,
    parameter int DW    = 8,
    parameter int AW    = aw_f(DIM),
    parameter int ACC_W = acc_w_f(DW, DIM),
    parameter int RES_W = ACC_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             a_rd_en,
    output logic [AW-1:0]    a_addr,
    input  logic [DW-1:0]    a_rdata,
    output logic             b_rd_en,
    output logic [AW-1:0]    b_addr,
    input  logic [DW-1:0]    b_rdata,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [AW-1:0]    res_addr,
    output logic [RES_W-1:0] res_data
`ifdef MATMUL_SEQ_SAT_EN
    ,
    output logic             sat
`endif
);

    localparam int CW = cw_f(DIM);
    localparam logic [CW-1:0] LAST = CW'(DIM - 1);

    mm_state_e state, state_n;
    logic [CW-1:0] i, j, k;
    logic [CW-1:0] i_n, j_n, k_n;
    logic mac_clr, mac_en;
    logic [ACC_W-1:0] acc;
    logic is_fetch, is_write;

    matmul_mac #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (a_rdata),
        .b     (b_rdata),
        .acc   (acc)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
        end else begin
            state <= state_n;
            i     <= i_n;
            j     <= j_n;
            k     <= k_n;
        end
    end

    always_comb begin
        state_n = state;
        i_n     = i;
        j_n     = j;
        k_n     = k;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = FETCH;
                    i_n     = '0;
                    j_n     = '0;
                    k_n     = '0;
                    mac_clr = 1'b1;
                end
            end
            FETCH: state_n = MAC;
            MAC: begin
                mac_en = 1'b1;
                if (k == LAST) begin
                    state_n = WRITE;
                end else begin
                    k_n     = k + 1'b1;
                    state_n = FETCH;
                end
            end
            WRITE: begin
                if (res_ready) begin
                    mac_clr = 1'b1;
                    k_n     = '0;
                    j_n     = (j == LAST) ? '0 : j + 1'b1;
                    if (j == LAST) begin
                        i_n = (i == LAST) ? '0 : i + 1'b1;
                    end
                    state_n = (i == LAST && j == LAST) ? DONE : FETCH;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign is_fetch  = (state == FETCH);
    assign is_write  = (state == WRITE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign a_rd_en   = is_fetch;
    assign b_rd_en   = is_fetch;
    assign res_valid = is_write;

    // Addresses are forced to zero outside their active state.
    assign a_addr = is_fetch ? AW'(idx(int'(i), int'(k), DIM)) : '0;
    assign b_addr = is_fetch ? AW'(idx(int'(k), int'(j), DIM)) : '0;
    assign res_addr = is_write ? AW'(idx(int'(i), int'(j), DIM)) : '0;

`ifdef MATMUL_SEQ_SAT_EN
    logic over;
    if (RES_W < ACC_W) begin : g_ovf
        assign over = |acc[ACC_W-1:RES_W];
    end else begin : g_no_ovf
        assign over = 1'b0;
    end
    assign sat = is_write && over;
    assign res_data = !is_write ? '0 :
                      over      ? '1 : acc[RES_W-1:0];
`else
    assign res_data = is_write ? acc[RES_W-1:0] : '0;
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb_matmul_seq_ctrl: directed vector table plus reset/abort sequence,
// run against a full-width instance and a 16-bit result instance.
module tb_matmul_seq_ctrl;

    localparam int DIM   = 2;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int ACC_W = 17;
    localparam int NW    = 16;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic start = 1'b0;
    logic res_ready = 1'b1;

    always #5 CLK = ~CLK;

    logic busy, done, a_rd_en, b_rd_en, res_valid;
    logic [AW-1:0] a_addr, b_addr, res_addr;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [ACC_W-1:0] res_data;

    logic n_busy, n_done, n_a_rd_en, n_b_rd_en, n_res_valid;
    logic [AW-1:0] n_a_addr, n_b_addr, n_res_addr;
    logic [DW-1:0] n_a_rdata, n_b_rdata;
    logic [NW-1:0] n_res_data;
`ifdef MATMUL_SEQ_SAT_EN
    logic sat, n_sat;
`endif

    logic [DW-1:0] ma [DIM*DIM];
    logic [DW-1:0] mb [DIM*DIM];

    matmul_seq_ctrl #(.DIM(DIM), .DW(DW)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .a_rd_en   (a_rd_en),
        .a_addr    (a_addr),
        .a_rdata   (a_rdata),
        .b_rd_en   (b_rd_en),
        .b_addr    (b_addr),
        .b_rdata   (b_rdata),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_addr  (res_addr),
        .res_data  (res_data)
`ifdef MATMUL_SEQ_SAT_EN
        ,
        .sat       (sat)
`endif
    );

    matmul_seq_ctrl #(.DIM(DIM), .DW(DW), .RES_W(NW)) dut_n (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .busy      (n_busy),
        .done      (n_done),
        .a_rd_en   (n_a_rd_en),
        .a_addr    (n_a_addr),
        .a_rdata   (n_a_rdata),
        .b_rd_en   (n_b_rd_en),
        .b_addr    (n_b_addr),
        .b_rdata   (n_b_rdata),
        .res_valid (n_res_valid),
        .res_ready (res_ready),
        .res_addr  (n_res_addr),
        .res_data  (n_res_data)
`ifdef MATMUL_SEQ_SAT_EN
        ,
        .sat       (n_sat)
`endif
    );

    // Synchronous operand RAM models, one read port per instance.
    always @(posedge CLK) begin
        if (a_rd_en) a_rdata <= ma[a_addr];
        if (b_rd_en) b_rdata <= mb[b_addr];
        if (n_a_rd_en) n_a_rdata <= ma[n_a_addr];
        if (n_b_rd_en) n_b_rdata <= mb[n_b_addr];
    end

    typedef struct {
        int a [4];
        int b [4];
        int stall_elem;
        int stall_cyc;
        int poke_cyc;
        int exp [4];
        int span;
    } vec_t;

    vec_t vt [5];
    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input longint act,
                         input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint narrow_exp(input int v);
`ifdef MATMUL_SEQ_SAT_EN
        return (v >= 65536) ? 65535 : v;
`else
        return v % 65536;
`endif
    endfunction

    task automatic check_zero(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " a_rd_en"}, a_rd_en, 0);
        check({tag, " b_rd_en"}, b_rd_en, 0);
        check({tag, " a_addr"}, a_addr, 0);
        check({tag, " b_addr"}, b_addr, 0);
        check({tag, " res_valid"}, res_valid, 0);
        check({tag, " res_addr"}, res_addr, 0);
        check({tag, " res_data"}, res_data, 0);
        check({tag, " n_busy"}, n_busy, 0);
        check({tag, " n_res_valid"}, n_res_valid, 0);
        check({tag, " n_res_data"}, n_res_data, 0);
    endtask

    task automatic load(input int t);
        for (int e = 0; e < 4; e++) begin
            ma[e] = 8'(vt[t].a[e]);
            mb[e] = 8'(vt[t].b[e]);
        end
    endtask

    task automatic run(input int t);
        int ff, dc, nd, nres, stall;
        ff = -1;
        dc = -1;
        nd = 0;
        nres = 0;
        stall = 0;
        load(t);
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int cyc = 0; cyc < 300 && (dc < 0 || cyc < dc + 4); cyc++) begin
            start = (cyc == vt[t].poke_cyc);
            if (a_rd_en && ff < 0) ff = cyc;
            if (done) begin
                nd++;
                if (dc < 0) dc = cyc;
            end
            if (res_valid && nres == vt[t].stall_elem
                && stall < vt[t].stall_cyc) begin
                res_ready = 1'b0;
                check($sformatf("v%0d stall addr", t), res_addr, nres);
                check($sformatf("v%0d stall data", t), res_data,
                      vt[t].exp[nres]);
                stall++;
            end else if (res_valid) begin
                res_ready = 1'b1;
                if (nres < 4) begin
                    check($sformatf("v%0d addr%0d", t, nres),
                          res_addr, nres);
                    check($sformatf("v%0d data%0d", t, nres),
                          res_data, vt[t].exp[nres]);
                    check($sformatf("v%0d n_data%0d", t, nres),
                          n_res_data, narrow_exp(vt[t].exp[nres]));
                    check($sformatf("v%0d n_valid%0d", t, nres),
                          n_res_valid, 1);
`ifdef MATMUL_SEQ_SAT_EN
                    check($sformatf("v%0d sat%0d", t, nres), sat, 0);
                    check($sformatf("v%0d n_sat%0d", t, nres), n_sat,
                          (vt[t].exp[nres] >= 65536) ? 1 : 0);
`endif
                end
                nres++;
            end else begin
                res_ready = 1'b1;
            end
            @(negedge CLK);
        end
        start = 1'b0;
        res_ready = 1'b1;
        check($sformatf("v%0d result count", t), nres, 4);
        check($sformatf("v%0d done pulses", t), nd, 1);
        check($sformatf("v%0d fetch..done span", t), dc - ff + 1,
              vt[t].span);
        check($sformatf("v%0d busy after", t), busy, 0);
    endtask

    initial begin
        vt[0] = '{a: '{1, 2, 3, 4}, b: '{5, 6, 7, 8},
                  stall_elem: -1, stall_cyc: 0, poke_cyc: -1,
                  exp: '{19, 22, 43, 50}, span: 21};
        vt[1] = '{a: '{255, 255, 255, 255}, b: '{255, 255, 255, 255},
                  stall_elem: -1, stall_cyc: 0, poke_cyc: -1,
                  exp: '{130050, 130050, 130050, 130050}, span: 21};
        vt[2] = '{a: '{1, 2, 3, 4}, b: '{5, 6, 7, 8},
                  stall_elem: 1, stall_cyc: 5, poke_cyc: -1,
                  exp: '{19, 22, 43, 50}, span: 26};
        vt[3] = '{a: '{1, 2, 3, 4}, b: '{5, 6, 7, 8},
                  stall_elem: -1, stall_cyc: 0, poke_cyc: 7,
                  exp: '{19, 22, 43, 50}, span: 21};
        vt[4] = '{a: '{0, 255, 10, 1}, b: '{3, 0, 200, 7},
                  stall_elem: 3, stall_cyc: 2, poke_cyc: -1,
                  exp: '{51000, 1785, 230, 7}, span: 23};

        #3;
        check_zero("reset");
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check_zero("idle");

        for (int t = 0; t < 5; t++) run(t);

        // Abort during the MAC cycle of element 2, then rerun cleanly.
        begin
            int nres;
            nres = 0;
            load(0);
            @(negedge CLK);
            start = 1'b1;
            @(negedge CLK);
            start = 1'b0;
            for (int c = 0; c < 100 && nres < 2; c++) begin
                if (res_valid) nres++;
                @(negedge CLK);
            end
            check("abort reached el2", nres, 2);
            check("el2 fetch strobe", a_rd_en, 1);
            check("el2 a_addr", a_addr, 2);
            check("el2 b_addr", b_addr, 0);
            @(negedge CLK);
            check("el2 mac busy", busy, 1);
            check("el2 mac no strobe", a_rd_en, 0);
            RST_N = 1'b0;
            #1;
            check_zero("abort");
            @(negedge CLK);
            check_zero("abort held");
            RST_N = 1'b1;
            @(negedge CLK);
            run(0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
Sequencer for the square integer matrix-multiply datapath. It walks the i/j/k loop nest and issues read addresses to two external synchronous operand RAMs (matrix 1, matrix 2). It accumulates products in a single multiply-accumulate unit and streams each result element out over a valid/ready port. It sits between the operand buffers and the result buffer, and its start/busy/done handshake is controlled by the top-level host logic.

Parameters:
DIM, 2, matrix dimension (square, DIM>=2)
DW, 8, operand width, unsigned
AW, $clog2(DIM*DIM), element address width (minimum 1)
ACC_W, 2*DW+$clog2(DIM), accumulator width; full precision, never overflows
RES_W, ACC_W, result port width (RES_W<=ACC_W)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  async active-low reset
start  in  1  single-cycle request to begin a multiply
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last result is accepted
a_rd_en  out  1  matrix-1 RAM read strobe
a_addr  out  AW  matrix-1 element address, row-major i*DIM+k
a_rdata  in  DW  matrix-1 data, valid the cycle after a_rd_en
b_rd_en  out  1  matrix-2 RAM read strobe
b_addr  out  AW  matrix-2 element address, k*DIM+j
b_rdata  in  DW  matrix-2 data, valid the cycle after b_rd_en
res_valid  out  1  result element valid
res_ready  in  1  result sink ready
res_addr  out  AW  result address, i*DIM+j
res_data  out  RES_W  result element value

Behaviour:
- Reset (async assert, sync release): state=IDLE, i=j=k=0, acc=0. All outputs are 0.
- FSM states: IDLE, FETCH, MAC, WRITE, DONE.
- IDLE: start=1 moves to FETCH and clears i, j, k and acc. start in any other state is ignored and has no queuing.
- FETCH: a_rd_en=b_rd_en=1 for exactly one cycle, with addresses from the current i, j, k. Next state is MAC.
- MAC: acc <= acc + a_rdata*b_rdata, unsigned with full-width product.
  - If k==DIM-1, go to WRITE.
  - Otherwise k++ and go to FETCH.
- WRITE: res_valid=1, res_data=acc (truncated to RES_W LSBs when the macro below is absent), res_addr=i*DIM+j.
  - Outputs stay stable while res_ready=0.
  - On res_valid&&res_ready: clear acc and k=0. Advance j; on j wrap (DIM-1 to 0), advance i.
  - If the element just accepted was (DIM-1,DIM-1), go to DONE. Otherwise go to FETCH.
- DONE: done=1 for one cycle, then go to IDLE.
- busy=1 in FETCH, MAC, WRITE and DONE; busy=0 in IDLE.
- Latency:
  - Each element takes 2*DIM cycles plus 1 WRITE cycle with no backpressure.
  - A full multiply is DIM*DIM*(2*DIM+1) cycles plus 1 DONE cycle.
  - For DIM=2: 21 cycles from the first FETCH to done.
- Result order is row-major, i outer and j inner.
- Read strobes are never asserted outside FETCH. The operand RAMs must be stable while busy=1.
- Reset mid-operation aborts immediately. No partial done is produced and res_valid drops asynchronously.

Optional Feature:
- Macro: MATMUL_SEQ_SAT_EN.
- Defined: res_data saturates to 2^RES_W-1 when acc>=2^RES_W. An extra output `sat` (1 bit) is asserted with res_valid for a saturated element.
- Undefined: res_data is the RES_W LSBs of acc and the `sat` port does not exist.
- With RES_W==ACC_W, the macro has no functional effect.

Decomposition:
- Shared package matmul_pkg holds:
  - the state enum (IDLE/FETCH/MAC/WRITE/DONE)
  - localparam functions for AW/ACC_W
  - the row-major index helper `idx(row,col,DIM)`
- One sub-module is natural: matmul_mac, with DW inputs, an ACC_W accumulator, and clear/enable controls. It is reusable by future parallel-lane variants.
- Loop counters and the FSM stay in matmul_seq_ctrl.

Test Plan:
- DIM=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], res_ready=1:
  - results (addr:data) are 0:19, 1:22, 2:43, 3:50 in that order
  - done is asserted exactly 21 cycles after the first FETCH.
- DIM=2, all operands 255: each result is 130050 with no truncation at the default ACC_W=17.
- Backpressure: same operands as the first test, with res_ready held low for 5 cycles on element 1.
  - res_valid, res_addr=1 and res_data=22 stay stable throughout the stall.
  - done is delayed by exactly 5 cycles.
- A pulse of start while busy is ignored. Only one done pulse occurs, and the result sequence is unchanged.
- RST_N asserted during the MAC state of element 2:
  - all outputs go to 0 immediately
  - a fresh start afterwards yields the correct full sequence from element 0.
- With MATMUL_SEQ_SAT_EN and RES_W=16, operands all 255:
  - res_data=65535 with sat=1 for every element
  - without the macro, res_data=0xFC02 (130050 mod 65536).
